seq_alu: RTL

- Parametrised, handshaked ALU for the multi-cycle CPU datapath. Successor to the combinational single-cycle ALU.
- Adds configurable width, signed compare and shift, XOR, and iterative unsigned multiply and divide.
- Adds registered results with valid/ready handshaking and status flags (zero, signed overflow, error).
- Sits between the register-file read stage and the write-back mux. The controller stalls on in_ready/out_valid.

---
 rtl/seq_alu.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU with iterative unsigned multiply/divide and status flags
module seq_alu #(
    parameter int  WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLTU = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MULU = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             zero_q;
    logic             overflow_q;
    logic             err_q;

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_err;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign err       = err_q;

    always_comb begin
        sh      = b[SHW-1:0];
        sum     = a + b;
        diff    = a - b;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLTU: alu_res = WIDTH'(a < b);
            OP_SRL:  alu_res = a >> sh;
            OP_SLL:  alu_res = a << sh;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            OP_SRA:  alu_res = $unsigned($signed(a) >>> sh);
            OP_MULU, OP_DIVU: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // {hi_q, lo_q} is the shared product / remainder:quotient register pair
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh  = {hi_q, lo_q[WIDTH-1]};
        div_sub = div_sh - {1'b0, b_q};
        div_ge  = (div_sh >= {1'b0, b_q});
        if (is_div_q) begin
            hi_d = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MULU || (op == OP_DIVU && b != '0)) begin
                            state_q  <= BUSY;
                            cnt_q    <= CW'(WIDTH);
                            is_div_q <= (op == OP_DIVU);
                            b_q      <= b;
                            hi_q     <= '0;
                            lo_q     <= a;
                        end else if (op == OP_DIVU) begin
                            state_q     <= DONE;
                            result_q    <= '1;
                            result_hi_q <= a;
                            zero_q      <= 1'b0;
                            overflow_q  <= 1'b0;
                            err_q       <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            result_q    <= alu_res;
                            result_hi_q <= '0;
                            zero_q      <= (alu_res == '0);
                            overflow_q  <= alu_ovf;
                            err_q       <= alu_err;
                        end
                    end
                end
                // WIDTH iterations, then one extra edge to publish the result
                BUSY: begin
                    if (cnt_q != '0) begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        state_q     <= DONE;
                        result_q    <= lo_q;
                        result_hi_q <= hi_q;
                        zero_q      <= (lo_q == '0);
                        overflow_q  <= 1'b0;
                        err_q       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
